// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM encoding and decode helpers for alu_seq
package alu_pkg;

    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_XOR   = 4'b0011;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_SLT   = 4'b0111;
    localparam logic [3:0] CTL_MUL   = 4'b1000;
    localparam logic [3:0] CTL_MULHU = 4'b1001;
    localparam logic [3:0] CTL_DIV   = 4'b1100;
    localparam logic [3:0] CTL_DIVU  = 4'b1101;
    localparam logic [3:0] CTL_REM   = 4'b1110;
    localparam logic [3:0] CTL_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_mul_code(input logic [3:0] ctl);
        return ctl[3:1] == 3'b100;
    endfunction

    function automatic logic is_div_code(input logic [3:0] ctl);
        return ctl[3:2] == 2'b11;
    endfunction

    function automatic logic is_muldiv(input logic [3:0] ctl);
        return is_mul_code(ctl) || is_div_code(ctl);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - iterative shift-add multiplier and restoring divider
module alu_muldiv_core #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    output logic                done,
    output logic [WORDSIZE-1:0] result
);

    localparam int CW = $clog2(WORDSIZE) + 1;

    logic                busy;
    logic [CW-1:0]       cnt;
    logic [WORDSIZE-1:0] hi, lo, d;
    logic                is_div, want_hi, neg_q, neg_r;

    logic                op_div, op_signed, a_neg, b_neg;
    logic [WORDSIZE-1:0] a_mag, b_mag;
    logic [WORDSIZE:0]   mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [WORDSIZE-1:0] sel;

    // op[2] separates divide from multiply; op[0]==0 marks the signed divide forms
    assign op_div    = op[2];
    assign op_signed = op_div & ~op[0];
    assign a_neg     = op_signed & a[WORDSIZE-1];
    assign b_neg     = op_signed & b[WORDSIZE-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // hi accumulates the product high half / partial remainder, lo holds multiplier / quotient
    assign mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, d}) : {1'b0, hi};
    assign div_shift = {hi, lo[WORDSIZE-1]};
    assign div_diff  = div_shift - {1'b0, d};
    assign div_ge    = ~div_diff[WORDSIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            d       <= '0;
            is_div  <= 1'b0;
            want_hi <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CW'(WORDSIZE);
            hi      <= '0;
            lo      <= op_div ? a_mag : b;
            d       <= op_div ? b_mag : a;
            is_div  <= op_div;
            want_hi <= op_div ? op[1] : op[0];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
        end else if (busy) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                if (is_div) begin
                    hi <= div_ge ? div_diff[WORDSIZE-1:0] : div_shift[WORDSIZE-1:0];
                    lo <= {lo[WORDSIZE-2:0], div_ge};
                end else begin
                    {hi, lo} <= {mul_sum, lo[WORDSIZE-1:1]};
                end
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done   = busy & (cnt == '0);
    assign sel    = want_hi ? hi : lo;
    assign result = (is_div & (want_hi ? neg_r : neg_q)) ? -sel : sel;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked execution unit: single-cycle ALU ops plus iterative mul/div
module alu_seq
    import alu_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter bit MUL_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] A,
    input  logic [WORDSIZE-1:0] B,
    input  logic [3:0]          CTL,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] R,
    output logic                Z,
    output logic                err
);

    localparam logic [WORDSIZE-1:0] MIN = {1'b1, {(WORDSIZE-1){1'b0}}};

    state_t              state, state_nx;
    logic                accept, b_zero, ovf, special, go_mul, go_div;
    logic [WORDSIZE-1:0] q_r;
    logic                q_err;
    logic                core_done;
    logic [WORDSIZE-1:0] core_result;

    assign accept  = in_valid & in_ready;
    assign b_zero  = (B == '0);
    assign ovf     = ~CTL[0] & (A == MIN) & (B == '1);
    assign special = is_div_code(CTL) & (b_zero | ovf);
    assign go_mul  = accept & MUL_EN & is_mul_code(CTL);
    assign go_div  = accept & MUL_EN & is_div_code(CTL) & ~special;

    // Everything that finishes in one cycle, including divide special cases and illegal codes
    always_comb begin
        q_r   = '0;
        q_err = 1'b0;
        case (CTL)
            CTL_AND: q_r = A & B;
            CTL_OR:  q_r = A | B;
            CTL_ADD: q_r = A + B;
            CTL_XOR: q_r = A ^ B;
            CTL_SUB: q_r = A - B;
            CTL_SLT: q_r = {{(WORDSIZE-1){1'b0}}, $signed(A) < $signed(B)};
            default: begin
                if (MUL_EN && is_muldiv(CTL)) begin
                    if (b_zero)
                        q_r = CTL[1] ? A : '1;
                    else if (ovf)
                        q_r = CTL[1] ? '0 : MIN;
                end else begin
                    q_err = 1'b1;
                end
            end
        endcase
    end

    generate
        if (MUL_EN) begin : g_core
            alu_muldiv_core #(.WORDSIZE(WORDSIZE)) u_core (
                .clk    (clk),
                .rst    (rst),
                .start  (go_mul | go_div),
                .op     (CTL[2:0]),
                .a      (A),
                .b      (B),
                .done   (core_done),
                .result (core_result)
            );
        end else begin : g_no_core
            assign core_done   = 1'b0;
            assign core_result = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nx = go_mul ? ST_MUL : (go_div ? ST_DIV : ST_DONE);
            end
            ST_MUL, ST_DIV: begin
                if (core_done)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Result registers only load on entry to DONE, so they hold through backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            R   <= '0;
            Z   <= 1'b1;
            err <= 1'b0;
        end else if (accept && !go_mul && !go_div) begin
            R   <= q_r;
            Z   <= (q_r == '0);
            err <= q_err;
        end else if ((state == ST_MUL || state == ST_DIV) && core_done) begin
            R   <= core_result;
            Z   <= (core_result == '0);
            err <= 1'b0;
        end
    end

endmodule
